// File: rtl/cnn_pkg.sv
// Shared definitions for the CNN datapath blocks.
//  - CNN_DATA_W / CNN_ADDR_W : default pixel and buffer address widths
//  - maxp_state_e            : state encoding of the max-pooling engine
//  - maxp_tap()              : buffer offset of window tap k (0..3) for a map of width img_w
package cnn_pkg;

    localparam int CNN_DATA_W = 16;
    localparam int CNN_ADDR_W = 10;

    typedef enum logic [2:0] {
        MAXP_IDLE = 3'd0,
        MAXP_RD0  = 3'd1,
        MAXP_RD1  = 3'd2,
        MAXP_RD2  = 3'd3,
        MAXP_RD3  = 3'd4,
        MAXP_CMP  = 3'd5,
        MAXP_WR   = 3'd6
    } maxp_state_e;

    // 2x2 window taps in row-major order: top-left, top-right, bottom-left, bottom-right
    function automatic int unsigned maxp_tap(input logic [1:0] k, input int unsigned img_w);
        case (k)
            2'd0:    return 32'd0;
            2'd1:    return 32'd1;
            2'd2:    return img_w;
            default: return img_w + 32'd1;
        endcase
    endfunction

endpackage

// File: rtl/maxp_engine_max2.sv
// Combinational signed maximum of two operands.
//  i_a, i_b : DATA_W-bit two's complement operands
//  o_max    : the larger of the two (either one on a tie)
module max2 #(
    parameter int DATA_W = 16
) (
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    output logic [DATA_W-1:0] o_max
);

    assign o_max = ($signed(i_a) > $signed(i_b)) ? i_a : i_b;

endmodule

// File: rtl/maxp_engine.sv
// 2x2 / stride-2 max-pooling engine answering the controller's en/done handshake.
// Reads an IMG_W x IMG_H map at SRC_BASE, writes the (IMG_W/2) x (IMG_H/2) pooled
// map at DST_BASE, six cycles per output (RD0..RD3, CMP, WR).
//  clk, rst          : clock; asynchronous active-low reset
//  en                : one-cycle start pulse (ignored while a pass is running)
//  done, busy        : pass-complete level / pass-in-progress level
//  rd_en/rd_addr     : buffer read port, rd_data valid one cycle after rd_en
//  wr_en/wr_addr/wr_data : buffer write port for pooled pixels
module maxp_engine
    import cnn_pkg::*;
#(
    parameter int DATA_W   = CNN_DATA_W,
    parameter int ADDR_W   = CNN_ADDR_W,
    parameter int IMG_W    = 8,
    parameter int IMG_H    = 8,
    parameter int SRC_BASE = 0,
    parameter int DST_BASE = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    output logic              done,
    output logic              busy,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data
);

    localparam int OW = IMG_W / 2;
    localparam int OH = IMG_H / 2;
    localparam logic GEOM_OK = (OW > 0) && (OH > 0);
    localparam logic [ADDR_W-1:0] OW_A    = ADDR_W'(OW);
    localparam logic [ADDR_W-1:0] OH_A    = ADDR_W'(OH);
    localparam logic [ADDR_W-1:0] IMG_W_A = ADDR_W'(IMG_W);
    localparam logic [ADDR_W-1:0] SRC_A   = ADDR_W'(SRC_BASE);
    localparam logic [ADDR_W-1:0] DST_A   = ADDR_W'(DST_BASE);
    localparam logic [ADDR_W-1:0] ONE_A   = ADDR_W'(1);

    maxp_state_e       r_state;
    maxp_state_e       w_state_nxt;
    logic [ADDR_W-1:0] r_ox, r_oy;
    logic [ADDR_W-1:0] w_ox_nxt, w_oy_nxt;
    logic [DATA_W-1:0] r_max;
    logic [DATA_W-1:0] w_max_s;
    logic [DATA_W-1:0] w_max_nxt;
    logic              r_pend;
    logic [1:0]        w_tap_k;
    logic              w_rd_en_nxt, w_wr_en_nxt;
    logic [ADDR_W-1:0] w_rd_addr_nxt, w_wr_addr_nxt;
    logic              w_ox_last, w_oy_last;

    max2 #(.DATA_W(DATA_W)) u_max2 (
        .i_a   (r_max),
        .i_b   (rd_data),
        .o_max (w_max_s)
    );

    assign w_ox_last = (r_ox == (OW_A - ONE_A));
    assign w_oy_last = (r_oy == (OH_A - ONE_A));

    // Next state and next output-position counters
    always_comb begin
        w_state_nxt = r_state;
        w_ox_nxt    = r_ox;
        w_oy_nxt    = r_oy;
        case (r_state)
            MAXP_IDLE: begin
                w_ox_nxt = '0;
                w_oy_nxt = '0;
                // A degenerate geometry never leaves IDLE; done is pulsed via r_pend
                if (en && GEOM_OK) begin
                    w_state_nxt = MAXP_RD0;
                end else begin
                    w_state_nxt = MAXP_IDLE;
                end
            end
            MAXP_RD0: w_state_nxt = MAXP_RD1;
            MAXP_RD1: w_state_nxt = MAXP_RD2;
            MAXP_RD2: w_state_nxt = MAXP_RD3;
            MAXP_RD3: w_state_nxt = MAXP_CMP;
            MAXP_CMP: w_state_nxt = MAXP_WR;
            MAXP_WR: begin
                if (w_ox_last) begin
                    w_ox_nxt = '0;
                    if (w_oy_last) begin
                        w_oy_nxt    = '0;
                        w_state_nxt = MAXP_IDLE;
                    end else begin
                        w_oy_nxt    = r_oy + ONE_A;
                        w_state_nxt = MAXP_RD0;
                    end
                end else begin
                    w_ox_nxt    = r_ox + ONE_A;
                    w_state_nxt = MAXP_RD0;
                end
            end
            default: w_state_nxt = MAXP_IDLE;
        endcase
    end

    // Output values for the coming state, so every port is driven from a flop
    always_comb begin
        case (w_state_nxt)
            MAXP_RD0: w_tap_k = 2'd0;
            MAXP_RD1: w_tap_k = 2'd1;
            MAXP_RD2: w_tap_k = 2'd2;
            default:  w_tap_k = 2'd3;
        endcase
        case (r_state)
            MAXP_RD1:                     w_max_nxt = rd_data;
            MAXP_RD2, MAXP_RD3, MAXP_CMP: w_max_nxt = w_max_s;
            default:                      w_max_nxt = r_max;
        endcase
        w_rd_en_nxt = (w_state_nxt == MAXP_RD0) || (w_state_nxt == MAXP_RD1) ||
                      (w_state_nxt == MAXP_RD2) || (w_state_nxt == MAXP_RD3);
        w_wr_en_nxt = (w_state_nxt == MAXP_WR);
        if (w_rd_en_nxt) begin
            w_rd_addr_nxt = SRC_A + ((w_oy_nxt << 1) * IMG_W_A) + (w_ox_nxt << 1)
                          + ADDR_W'(maxp_tap(w_tap_k, IMG_W));
        end else begin
            w_rd_addr_nxt = '0;
        end
        if (w_wr_en_nxt) begin
            w_wr_addr_nxt = DST_A + (w_oy_nxt * OW_A) + w_ox_nxt;
        end else begin
            w_wr_addr_nxt = '0;
        end
    end

    // State, counters, running max and buffer port registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= MAXP_IDLE;
            r_ox    <= '0;
            r_oy    <= '0;
            r_max   <= '0;
            busy    <= 1'b0;
            rd_en   <= 1'b0;
            rd_addr <= '0;
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ox    <= w_ox_nxt;
            r_oy    <= w_oy_nxt;
            r_max   <= w_max_nxt;
            busy    <= (w_state_nxt != MAXP_IDLE);
            rd_en   <= w_rd_en_nxt;
            rd_addr <= w_rd_addr_nxt;
            wr_en   <= w_wr_en_nxt;
            wr_addr <= w_wr_addr_nxt;
            wr_data <= w_wr_en_nxt ? w_max_nxt : '0;
        end
    end

    // done handshake: cleared on an accepted start, set after the last write
    // (or one cycle after the start when there is nothing to pool)
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            done   <= 1'b0;
            r_pend <= 1'b0;
        end else if ((r_state == MAXP_IDLE) && en) begin
            done   <= 1'b0;
            r_pend <= !GEOM_OK;
        end else if (r_pend) begin
            done   <= 1'b1;
            r_pend <= 1'b0;
        end else if ((r_state == MAXP_WR) && (w_state_nxt == MAXP_IDLE)) begin
            done   <= 1'b1;
            r_pend <= 1'b0;
        end else begin
            done   <= done;
            r_pend <= 1'b0;
        end
    end

endmodule

// File: tb/tb_maxp_engine.sv
// Directed bench for maxp_engine: a 4x4 instance (main tests) and a 5x5 instance
// (odd geometry). The buffer is modelled as a function of address; writes and
// reads are logged and compared against hand-computed values.
module tb_maxp_engine;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, en, en5, tb_clr;
    int          mode;
    int          n_chk, n_fail;

    logic        done_a, busy_a, rd_en_a, wr_en_a;
    logic [9:0]  rd_addr_a, wr_addr_a;
    logic [15:0] rd_data_a, wr_data_a;
    logic        done_b, busy_b, rd_en_b, wr_en_b;
    logic [9:0]  rd_addr_b, wr_addr_b;
    logic [15:0] rd_data_b, wr_data_b;

    maxp_engine #(.DATA_W(16), .ADDR_W(10), .IMG_W(4), .IMG_H(4),
                  .SRC_BASE(0), .DST_BASE(256)) u_dut (
        .clk(clk), .rst(rst), .en(en), .done(done_a), .busy(busy_a),
        .rd_en(rd_en_a), .rd_addr(rd_addr_a), .rd_data(rd_data_a),
        .wr_en(wr_en_a), .wr_addr(wr_addr_a), .wr_data(wr_data_a)
    );

    maxp_engine #(.DATA_W(16), .ADDR_W(10), .IMG_W(5), .IMG_H(5),
                  .SRC_BASE(0), .DST_BASE(256)) u_dut5 (
        .clk(clk), .rst(rst), .en(en5), .done(done_b), .busy(busy_b),
        .rd_en(rd_en_b), .rd_addr(rd_addr_b), .rd_data(rd_data_b),
        .wr_en(wr_en_b), .wr_addr(wr_addr_b), .wr_data(wr_data_b)
    );

    // Buffer contents: mode 0 = value equals address; mode 1 = all -5, address 6 = -1
    function automatic logic [15:0] src_val(input int m, input logic [9:0] a);
        if (m == 0) return {6'd0, a};
        else if (a == 10'd6) return 16'hFFFF;
        else return 16'hFFFB;
    endfunction

    logic [9:0]  wl_addr [32];
    logic [15:0] wl_data [32];
    logic [9:0]  rl_addr [64];
    logic [9:0]  wb_addr [8];
    logic [15:0] wb_data [8];
    int wcnt, rcnt, wcnt_b, rcnt_b, bad_b;

    // Read-data model and access logs for both instances
    always @(posedge clk) begin
        rd_data_a <= rd_en_a ? src_val(mode, rd_addr_a) : 16'h0000;
        rd_data_b <= rd_en_b ? src_val(0, rd_addr_b) : 16'h0000;
        if (tb_clr) begin
            wcnt <= 0; rcnt <= 0; wcnt_b <= 0; rcnt_b <= 0; bad_b <= 0;
        end else begin
            if (wr_en_a) begin
                if (wcnt < 32) begin
                    wl_addr[wcnt[4:0]] <= wr_addr_a;
                    wl_data[wcnt[4:0]] <= wr_data_a;
                end
                wcnt <= wcnt + 1;
            end
            if (rd_en_a) begin
                if (rcnt < 64) rl_addr[rcnt[5:0]] <= rd_addr_a;
                rcnt <= rcnt + 1;
            end
            if (wr_en_b) begin
                if (wcnt_b < 8) begin
                    wb_addr[wcnt_b[2:0]] <= wr_addr_b;
                    wb_data[wcnt_b[2:0]] <= wr_data_b;
                end
                wcnt_b <= wcnt_b + 1;
            end
            if (rd_en_b) begin
                rcnt_b <= rcnt_b + 1;
                if ((rd_addr_b % 10'd5 == 10'd4) || (rd_addr_b >= 10'd20)) bad_b <= bad_b + 1;
            end
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clear_logs();
        @(negedge clk); tb_clr = 1'b1;
        @(negedge clk); tb_clr = 1'b0;
    endtask

    task automatic check_idle_outputs(input string tag);
        check_eq(tag, {28'd0, done_a, busy_a, rd_en_a, wr_en_a}, 32'd0);
        check_eq({tag, "_addr"}, {12'd0, rd_addr_a, wr_addr_a}, 32'd0);
        check_eq({tag, "_wdata"}, {16'd0, wr_data_a}, 32'd0);
    endtask

    // Pulse en on instance A, then check done/busy for 25 cycles; optional re-pulse
    task automatic run_pass_a(input int repulse_at);
        @(negedge clk); en = 1'b1;
        for (int k = 1; k <= 25; k++) begin
            @(negedge clk);
            check_eq($sformatf("done_c%0d", k), {31'd0, done_a}, (k >= 25) ? 32'd1 : 32'd0);
            check_eq($sformatf("busy_c%0d", k), {31'd0, busy_a}, (k <= 24) ? 32'd1 : 32'd0);
            if (k == 1) en = 1'b0;
            if (k == repulse_at) en = 1'b1;
            if (k == repulse_at + 1) en = 1'b0;
        end
    endtask

    task automatic check_writes(input string tag, input logic [15:0] e0, input logic [15:0] e1,
                                input logic [15:0] e2, input logic [15:0] e3);
        logic [15:0] exp_d [4];
        exp_d[0] = e0; exp_d[1] = e1; exp_d[2] = e2; exp_d[3] = e3;
        check_eq({tag, "_wcnt"}, wcnt, 32'd4);
        for (int i = 0; i < 4; i++) begin
            check_eq($sformatf("%s_waddr%0d", tag, i), {22'd0, wl_addr[i]}, 32'd256 + i);
            check_eq($sformatf("%s_wdata%0d", tag, i), {16'd0, wl_data[i]}, {16'd0, exp_d[i]});
        end
    endtask

    initial begin
        n_chk = 0; n_fail = 0;
        rst = 1'b0; en = 1'b0; en5 = 1'b0; tb_clr = 1'b1; mode = 0;
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        check_eq("reset_b", {28'd0, done_b, busy_b, rd_en_b, wr_en_b}, 32'd0);
        rst = 1'b1;
        @(negedge clk); tb_clr = 1'b0;

        // 4x4 ramp
        clear_logs();
        run_pass_a(0);
        check_writes("ramp", 16'd5, 16'd7, 16'd13, 16'd15);
        check_eq("ramp_rcnt", rcnt, 32'd16);

        // signed data and window read order
        mode = 1;
        clear_logs();
        run_pass_a(0);
        check_writes("signed", 16'hFFFB, 16'hFFFF, 16'hFFFB, 16'hFFFB);
        for (int i = 0; i < 4; i++) begin
            logic [9:0] exp_ra [4];
            exp_ra[0] = 10'd0; exp_ra[1] = 10'd1; exp_ra[2] = 10'd4; exp_ra[3] = 10'd5;
            check_eq($sformatf("raddr%0d", i), {22'd0, rl_addr[i]}, {22'd0, exp_ra[i]});
        end

        // en re-pulsed mid-pass is ignored
        mode = 0;
        clear_logs();
        run_pass_a(10);
        check_writes("repulse", 16'd5, 16'd7, 16'd13, 16'd15);
        check_eq("repulse_idle", {31'd0, busy_a}, 32'd0);

        // reset in the middle of a pass
        @(negedge clk); en = 1'b1;
        for (int k = 1; k <= 18; k++) begin
            @(negedge clk);
            if (k == 1) en = 1'b0;
            if (k == 12) rst = 1'b0;
            if (k >= 12 && k <= 14) begin
                #1;
                check_idle_outputs($sformatf("midrst_c%0d", k));
            end
            if (k == 15) rst = 1'b1;
            if (k >= 16) check_eq($sformatf("postrst_done_c%0d", k), {31'd0, done_a}, 32'd0);
        end
        clear_logs();
        run_pass_a(0);
        check_writes("afterrst", 16'd5, 16'd7, 16'd13, 16'd15);

        // 5x5 map: odd column and row ignored
        @(negedge clk); en5 = 1'b1;
        @(negedge clk); en5 = 1'b0;
        check_eq("b_done_low", {31'd0, done_b}, 32'd0);
        repeat (30) @(negedge clk);
        check_eq("b_wcnt", wcnt_b, 32'd4);
        check_eq("b_rcnt", rcnt_b, 32'd16);
        check_eq("b_badreads", bad_b, 32'd0);
        check_eq("b_done", {31'd0, done_b}, 32'd1);
        begin
            logic [15:0] exp_b [4];
            exp_b[0] = 16'd6; exp_b[1] = 16'd8; exp_b[2] = 16'd16; exp_b[3] = 16'd18;
            for (int i = 0; i < 4; i++) begin
                check_eq($sformatf("b_waddr%0d", i), {22'd0, wb_addr[i]}, 32'd256 + i);
                check_eq($sformatf("b_wdata%0d", i), {16'd0, wb_data[i]}, {16'd0, exp_b[i]});
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
